// File: rtl/uart_fink_pkg.sv
// uart_fink_pkg: coded-frame size helper, shared defaults and rx FSM states.
package uart_fink_pkg;
  localparam int STEP_DEFAULT = 0;
  localparam int MSG_SIZE_DEFAULT = 6;
  localparam int CLKS_PER_BIT_DEFAULT = 434;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  function automatic int coded_size(input int msg, input int step);
    return 2 * (msg + 2 * (2 * step + 1));
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer plus falling-edge detect, idles high.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);
  logic s1, rx_prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, rx_s, rx_prev} <= 3'b111;
    else {s1, rx_s, rx_prev} <= {rx, s1, rx_s};
  assign fall = rx_prev & ~rx_s;
endmodule

// File: rtl/uart_coded_rx.sv
// uart_coded_rx: UART deserializer for one coded message per frame.
// Define UART_CODED_RX_PARITY_EN to add an even-parity bit before stop.
module uart_coded_rx
  import uart_fink_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int STEP = STEP_DEFAULT,
  parameter int MSG_SIZE = MSG_SIZE_DEFAULT,
  localparam int CODED_MSG_SIZE = coded_size(MSG_SIZE, STEP)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  output logic [CODED_MSG_SIZE-1:0] coded_out,
  output logic                      coded_valid,
  output logic                      frame_err,
  output logic                      busy
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(CODED_MSG_SIZE);
  localparam logic [BW-1:0] HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] FULL = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST = CW'(CODED_MSG_SIZE - 1);
  rx_state_t state;
  logic [BW-1:0] baud;
  logic [CW-1:0] bit_cnt;
  logic [CODED_MSG_SIZE-1:0] shift;
  logic rx_s, fall, good, tick;
  uart_rx_sync u_sync (.clk(clk), .rst_n(rst_n), .rx(rx), .rx_s(rx_s), .fall(fall));
  assign tick = baud == FULL;
`ifdef UART_CODED_RX_PARITY_EN
  logic par_ok;
  assign good = rx_s & par_ok;
`else
  assign good = rx_s;
`endif
  // busy is assigned alongside each state change so it tracks state != IDLE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      baud <= '0;
      bit_cnt <= '0;
      shift <= '0;
      coded_out <= '0;
      coded_valid <= 1'b0;
      frame_err <= 1'b0;
      busy <= 1'b0;
`ifdef UART_CODED_RX_PARITY_EN
      par_ok <= 1'b1;
`endif
    end else begin
      coded_valid <= 1'b0;
      frame_err <= 1'b0;
      baud <= baud + 1'b1;
      case (state)
        IDLE: begin
          busy <= fall;
          if (fall) begin
            state <= START;
            baud <= '0;
          end
        end
        START: if (baud == HALF) begin
          state <= rx_s ? IDLE : DATA;
          busy <= ~rx_s;
          baud <= '0;
          bit_cnt <= '0;
        end
        DATA: if (tick) begin
          baud <= '0;
          shift <= {rx_s, shift[CODED_MSG_SIZE-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
`ifdef UART_CODED_RX_PARITY_EN
          if (bit_cnt == LAST) state <= PARITY;
`else
          if (bit_cnt == LAST) state <= STOP;
`endif
        end
`ifdef UART_CODED_RX_PARITY_EN
        PARITY: if (tick) begin
          baud <= '0;
          par_ok <= ~^{shift, rx_s};
          state <= STOP;
        end
`endif
        STOP: if (tick) begin
          coded_valid <= good;
          frame_err <= ~good;
          if (good) coded_out <= shift;
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_coded_rx.sv
// tb_uart_coded_rx: scoreboard bench driving whole UART frames into uart_coded_rx.
module tb_uart_coded_rx;
  localparam int CPB = 8;
  localparam int N = 16;
`ifdef UART_CODED_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LAT = (2 * N + 3 + 2 * PB) * CPB / 2 + 3;
  typedef struct {
    logic err;
    logic [N-1:0] out;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic [N-1:0] coded_out;
  logic coded_valid, frame_err, busy;
  int checks = 0, errors = 0, cyc = 0, ev_cyc = 0, events = 0, start_cyc = 0;
  logic [N-1:0] model_out = '0;
  exp_t q[$];

  uart_coded_rx #(.CLKS_PER_BIT(CPB), .STEP(0), .MSG_SIZE(6)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .coded_out(coded_out),
    .coded_valid(coded_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (coded_valid || frame_err)) begin
      ev_cyc = cyc;
      events++;
      chk("pulse_expected", q.size() != 0, 1);
      chk("exclusive", coded_valid & frame_err, 0);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("frame_err", frame_err, e.err);
        chk("coded_valid", coded_valid, !e.err);
        chk("coded_out", coded_out, e.out);
      end
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [N-1:0] d, input logic stop, input logic par_good);
    logic ok;
    ok = stop && (PB == 0 || par_good);
    q.push_back('{err: !ok, out: ok ? d : model_out});
    if (ok) model_out = d;
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < N; i++) send_bit(d[i]);
    if (PB != 0) send_bit(^d ^ !par_good);
    send_bit(stop);
  endtask

  initial begin
    int e0, lat;
    logic [N-1:0] d;
    logic stop, par;
    for (int i = 0; i < 6; i++) begin
      rx = i[0];
      @(negedge clk);
      chk("rst_coded_out", coded_out, 0);
      chk("rst_valid", coded_valid, 0);
      chk("rst_err", frame_err, 0);
      chk("rst_busy", busy, 0);
    end
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_coded_out", coded_out, 0);
    chk("idle_busy", busy, 0);

    e0 = events;
    send_frame(16'hA5C3, 1'b1, 1'b1);
    chk("single_pulse_count", events - e0, 1);
    chk("single_out", coded_out, 16'hA5C3);
    lat = ev_cyc - start_cyc;
    checks++;
    if (lat < LAT - 1 || lat > LAT + 1) begin
      errors++;
      $display("FAIL latency: got %0d expected %0d +-1", lat, LAT);
    end

    e0 = events;
    send_frame(16'h1234, 1'b0, 1'b1);
    repeat (5 * CPB) @(negedge clk);
    chk("low_line_busy", busy, 0);
    chk("bad_stop_pulses", events - e0, 1);
    chk("bad_stop_keeps_out", coded_out, 16'hA5C3);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    e0 = events;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("glitch_busy_high", busy, 1);
    repeat (2 * CPB) @(negedge clk);
    chk("glitch_busy_low", busy, 0);
    chk("glitch_no_pulse", events - e0, 0);

    send_frame(16'h00FF, 1'b1, 1'b1);
    send_frame(16'hFF00, 1'b1, 1'b1);
    chk("b2b_out", coded_out, 16'hFF00);
    send_bit(1'b0);
    for (int i = 0; i < 6; i++) send_bit(i[0]);
    chk("mid_frame_busy", busy, 1);
    rst_n = 1'b0;
    model_out = '0;
    #1;
    chk("abort_out", coded_out, 0);
    chk("abort_busy", busy, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("abort_out_after", coded_out, 0);

`ifdef UART_CODED_RX_PARITY_EN
    send_frame(16'h0001, 1'b1, 1'b1);
    chk("parity_good_out", coded_out, 16'h0001);
    send_frame(16'h0001, 1'b1, 1'b0);
    send_frame(16'hBEEF, 1'b1, 1'b0);
    chk("parity_bad_keeps_out", coded_out, 16'h0001);
`endif

    for (int k = 0; k < 8; k++) begin
      d = N'($urandom);
      stop = $urandom_range(0, 3) != 0;
      par = $urandom_range(0, 3) != 0;
      send_frame(d, stop, par);
      if (!stop) begin
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
      end
      chk("random_out", coded_out, model_out);
    end

    repeat (20) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
